adder_bist: RTL and testbench

- Synthesizable built-in self-test block for the n-bit adders (csa, cra, cla, a1csa).
- Generates pseudo-random operands {cin, b, a} with an LFSR and drives them into a combinational adder instance.
- Compacts every {cout, s} response into a MISR signature and compares the final signature against a golden value.
- It is the hardware counterpart of the file-based vector reader: it produces stimulus on-chip and consumes the responses, so a pass/fail result is available without any log files.

---
 rtl/adder_bist.sv | 114 +++++++++++
 tb/tb_adder_bist.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_bist.sv
// Built-in self-test for an n-bit combinational adder: an LFSR supplies {cin, b, a},
// a MISR compacts every {cout, s}, and the final signature is compared with golden_sig.
module adder_bist #(
    parameter int           n           = 128,
    parameter int           NUM_VECTORS = 30000,
    parameter int           CW          = 16,
    parameter logic [2*n:0] SEED        = 1,
    parameter int           TAP         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [n:0]    golden_sig,
    output logic [n-1:0]  a,
    output logic [n-1:0]  b,
    output logic          cin,
    input  logic [n-1:0]  s,
    input  logic          cout,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [n:0]    sig,
    output logic [CW-1:0] vec_count
);

    localparam int W = 2 * n + 1;
    localparam int M = n + 1;
    localparam logic [W-1:0]  SEED_EFF = (SEED == '0) ? W'(1) : SEED;
    localparam logic [CW-1:0] LAST     = CW'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, DONE} state_t;

    state_t        state;
    logic [W-1:0]  r;
    logic [M-1:0]  m;
    logic [CW-1:0] count;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
        return {v[W-2:0], v[W-1] ^ v[TAP]};
    endfunction

    // Feedback polynomial x^M + x + 1: the top bit folds back into bits 0 and 1.
    function automatic logic [M-1:0] misr_step(input logic [M-1:0] v, input logic [M-1:0] d);
        logic [M-1:0] nx;
        nx[0] = v[M-1] ^ d[0];
        nx[1] = v[0] ^ v[M-1] ^ d[1];
        for (int i = 2; i < M; i++) begin
            nx[i] = v[i-1] ^ d[i];
        end
        return nx;
    endfunction

    assign a         = r[n-1:0];
    assign b         = r[2*n-1:n];
    assign cin       = r[2*n];
    assign sig       = m;
    assign vec_count = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            r     <= '0;
            m     <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r     <= SEED_EFF;
                    m     <= '0;
                    count <= '0;
                    pass  <= 1'b0;
                    state <= RUN;
                end
                RUN: begin
                    // The adder is combinational, so its response to r is sampled on this same edge.
                    m     <= misr_step(m, {cout, s});
                    count <= count + CW'(1);
                    r     <= lfsr_step(r);
                    if (count == LAST) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    pass  <= (m == golden_sig);
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: two small directed instances (n=4) and one randomized instance
// (n=12) checked every cycle against a sequence-level model of LFSR, adder and MISR.
module tb_adder_bist;

    localparam int N2   = 12;
    localparam int NV2  = 100;
    localparam int TAP2 = 7;
    localparam logic [2*N2:0] SEED2 = 25'h0ACE1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Small instances: u0 (zero seed, 1 vector), u1 (seed 1, 3 vectors)
    logic       start_s;
    logic [4:0] gold0, gold1;
    logic [3:0] a0, b0, s0, a1, b1, s1;
    logic       cin0, cout0, cin1, cout1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [4:0] sig0, sig1;
    logic [3:0] cnt0, cnt1;

    assign {cout0, s0} = 5'(a0) + 5'(b0) + 5'(cin0);
    assign {cout1, s1} = 5'(a1) + 5'(b1) + 5'(cin1);

    adder_bist #(.n(4), .NUM_VECTORS(1), .CW(4), .SEED(9'h000), .TAP(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .golden_sig(gold0),
        .a(a0), .b(b0), .cin(cin0), .s(s0), .cout(cout0),
        .busy(busy0), .done(done0), .pass(pass0), .sig(sig0), .vec_count(cnt0));

    adder_bist #(.n(4), .NUM_VECTORS(3), .CW(4), .SEED(9'h001), .TAP(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_s), .golden_sig(gold1),
        .a(a1), .b(b1), .cin(cin1), .s(s1), .cout(cout1),
        .busy(busy1), .done(done1), .pass(pass1), .sig(sig1), .vec_count(cnt1));

    // Randomized instance with an optional s[0] stuck-at-0 fault in its adder
    logic          start2, fault2;
    logic [N2:0]   gold2, sig2, sum2;
    logic [N2-1:0] a2, b2, s2;
    logic          cin2, cout2, busy2, done2, pass2;
    logic [7:0]    cnt2;

    assign sum2  = {1'b0, a2} + {1'b0, b2} + {{N2{1'b0}}, cin2};
    assign s2    = {sum2[N2-1:1], sum2[0] & ~fault2};
    assign cout2 = sum2[N2];

    adder_bist #(.n(N2), .NUM_VECTORS(NV2), .CW(8), .SEED(SEED2), .TAP(TAP2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .golden_sig(gold2),
        .a(a2), .b(b2), .cin(cin2), .s(s2), .cout(cout2),
        .busy(busy2), .done(done2), .pass(pass2), .sig(sig2), .vec_count(cnt2));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] msk(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] lfsr_nx(input logic [63:0] r, input int w, input int tap);
        return ((r << 1) | 64'(r[w-1] ^ r[tap])) & msk(w);
    endfunction

    // Multiply-by-x modulo x^mw + x + 1, then add the response word.
    function automatic logic [63:0] misr_nx(input logic [63:0] m, input logic [63:0] d, input int mw);
        return ((m << 1) ^ (m[mw-1] ? 64'd3 : 64'd0) ^ d) & msk(mw);
    endfunction

    function automatic logic [63:0] resp(input logic [63:0] r, input int nn, input bit fault);
        logic [63:0] sum;
        sum = (r & msk(nn)) + ((r >> nn) & msk(nn)) + ((r >> (2 * nn)) & 64'd1);
        if (fault) sum = sum & ~64'd1;
        return sum & msk(nn + 1);
    endfunction

    function automatic logic [63:0] run_sig(input int nn, input int tap, input logic [63:0] seed,
                                           input int nv, input bit fault);
        logic [63:0] r, m;
        r = (seed == 0) ? 64'd1 : seed;
        m = 0;
        for (int i = 0; i < nv; i++) begin
            m = misr_nx(m, resp(r, nn, fault), nn + 1);
            r = lfsr_nx(r, 2 * nn + 1, tap);
        end
        return m;
    endfunction

    // Model of u2: t counts cycles since a run was accepted (-1 = reset, never run).
    // exp_r[k] / exp_m[k] are the LFSR and MISR contents after k compacted vectors.
    int          t = -1;
    bit          exp_pass;
    logic [63:0] exp_r [0:NV2];
    logic [63:0] exp_m [0:NV2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t <= -1;
        end else if (t < 0 || t >= NV2 + 2) begin
            if (start2) begin
                logic [63:0] r, m;
                r = (SEED2 == 0) ? 64'd1 : 64'(SEED2);
                m = 0;
                for (int k = 0; k <= NV2; k++) begin
                    exp_r[k] <= r;
                    exp_m[k] <= m;
                    m = misr_nx(m, resp(r, N2, fault2), N2 + 1);
                    r = lfsr_nx(r, 2 * N2 + 1, TAP2);
                end
                t <= 0;
            end
        end else begin
            if (t == NV2 + 1) exp_pass <= (exp_m[NV2] == 64'(gold2));
            t <= t + 1;
        end
    end

    always @(negedge clk) begin
        if (t < 0) begin
            chk("u2_idle_ops", 64'({cin2, b2, a2}), 64'd0);
            chk("u2_idle_flags", 64'({busy2, done2, pass2}), 64'd0);
            chk("u2_idle_sig", 64'(sig2), 64'd0);
            chk("u2_idle_cnt", 64'(cnt2), 64'd0);
        end else if (t == 0) begin
            chk("u2_load_flags", 64'({busy2, done2}), 64'b10);
        end else begin
            int k;
            k = (t - 1 < NV2) ? t - 1 : NV2;
            chk("u2_ops", 64'({cin2, b2, a2}), exp_r[k]);
            chk("u2_sig", 64'(sig2), exp_m[k]);
            chk("u2_cnt", 64'(cnt2), 64'(k));
            chk("u2_flags", 64'({busy2, done2}), (t <= NV2 + 1) ? 64'b10 : 64'b01);
            if (t >= NV2 + 2) chk("u2_pass", 64'(pass2), 64'(exp_pass));
        end
    end

    initial begin
        logic [63:0] clean, faulty;
        rst_n = 1'b1; start_s = 1'b0; start2 = 1'b0; fault2 = 1'b0;
        gold0 = 5'h01; gold1 = 5'h04; gold2 = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_ops0", 64'({cin0, b0, a0}), 64'd0);
        chk("rst_async_flags0", 64'({busy0, done0, pass0}), 64'd0);
        chk("rst_async_sig0", 64'(sig0), 64'd0);
        chk("model_pin_nv1", run_sig(4, 4, 64'd1, 1, 1'b0), 64'h01);
        chk("model_pin_nv3", run_sig(4, 4, 64'd1, 3, 1'b0), 64'h04);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-vector match on u0, three-vector LFSR walk on u1
        tick; start_s = 1'b1;
        tick; start_s = 1'b0;
        tick;
        chk("run_ops0", 64'({cin0, b0, a0}), 64'h001);
        chk("run_busy0", 64'(busy0), 64'd1);
        chk("lfsr_a1_0", 64'({cin1, b1, a1}), 64'h001);
        tick;
        chk("done_early0", 64'(done0), 64'd0);
        chk("lfsr_a1_1", 64'({cin1, b1, a1}), 64'h002);
        tick;
        chk("done0", 64'({busy0, done0, pass0}), 64'b011);
        chk("sig0", 64'(sig0), 64'h01);
        chk("cnt0", 64'(cnt0), 64'd1);
        chk("lfsr_a1_2", 64'({cin1, b1, a1}), 64'h004);
        tick; tick;
        chk("done1", 64'({busy1, done1, pass1}), 64'b011);
        chk("sig1", 64'(sig1), 64'h04);
        chk("cnt1", 64'(cnt1), 64'd3);

        // Mismatch on u0; a start pulse mid-run must be ignored by both
        gold0 = 5'h02;
        start_s = 1'b1; tick; start_s = 1'b0;
        tick; start_s = 1'b1;
        tick; start_s = 1'b0;
        tick;
        chk("mismatch_pass0", 64'({done0, pass0}), 64'b10);
        chk("mismatch_sig0", 64'(sig0), 64'h01);
        tick; tick;
        chk("ign_start_done1", 64'({done1, pass1}), 64'b11);
        chk("ign_start_cnt1", 64'(cnt1), 64'd3);
        tick;
        chk("done_hold1", 64'({busy1, done1, sig1}), 64'({2'b01, 5'h04}));

        // Start held high: back-to-back runs with one DONE cycle between
        start_s = 1'b1;
        repeat (6) tick;
        chk("hold_done1", 64'({done1, sig1}), 64'({1'b1, 5'h04}));
        tick;
        chk("hold_reload1", 64'({busy1, done1}), 64'b10);
        repeat (5) tick;
        chk("hold_rerun1", 64'({done1, sig1, cnt1}), 64'({1'b1, 5'h04, 4'd3}));
        start_s = 1'b0;
        repeat (6) tick;

        // Asynchronous reset in the middle of a run
        start_s = 1'b1; tick; start_s = 1'b0;
        tick; tick;
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_rst_ops1", 64'({cin1, b1, a1}), 64'd0);
        chk("midrun_rst_flags1", 64'({busy1, done1, pass1}), 64'd0);
        chk("midrun_rst_sig1", 64'({sig1, cnt1}), 64'd0);
        tick; rst_n = 1'b1;
        tick;

        // Randomized runs on u2
        clean  = run_sig(N2, TAP2, 64'(SEED2), NV2, 1'b0);
        faulty = run_sig(N2, TAP2, 64'(SEED2), NV2, 1'b1);
        for (int it = 0; it < 12; it++) begin
            bit hold, dorst;
            int mode, rcyc, cyc;
            fault2 = (it == 0) ? 1'b0 : (it == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            mode   = (it < 2) ? 0 : int'($urandom_range(0, 2));
            gold2  = (mode == 0) ? clean[N2:0] : (mode == 1) ? faulty[N2:0] : (N2+1)'($urandom);
            hold   = (it >= 2) && ($urandom_range(0, 3) == 0);
            dorst  = (it >= 2) && ($urandom_range(0, 4) == 0);
            rcyc   = int'($urandom_range(2, NV2));
            start2 = 1'b1; tick;
            if (!hold) start2 = 1'b0;
            cyc = 0;
            while (!done2 && cyc < 400) begin
                if (dorst && cyc == rcyc) break;
                if (!hold) start2 = (busy2 && cnt2 < 8'(NV2 - 4)) ? 1'($urandom_range(0, 1)) : 1'b0;
                tick;
                cyc++;
            end
            if (dorst && cyc == rcyc && !done2) begin
                #1 rst_n = 1'b0;
                #1 chk("rand_rst_u2", 64'({busy2, done2, sig2}), 64'd0);
                start2 = 1'b0;
                tick; rst_n = 1'b1;
                tick;
            end else if (!done2) begin
                chk("u2_done_timeout", 64'd0, 64'd1);
                start2 = 1'b0;
            end else begin
                if (mode == 0 && !fault2) chk("clean_pass", 64'(pass2), 64'd1);
                if (mode == 0 && fault2 && clean != faulty) chk("fault_detect", 64'(pass2), 64'd0);
                if (hold) begin
                    tick;
                    start2 = 1'b0;
                    cyc = 0;
                    while (!done2 && cyc < 400) begin
                        tick;
                        cyc++;
                    end
                    chk("rerun_sig_u2", 64'(sig2), fault2 ? faulty : clean);
                end
                tick; tick;
            end
        end

        repeat (3) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
